memory_access_unit: RTL and testbench

- Sequences every data-memory access issued by the CPU datapath.
- Accepts one load/store per instruction from the decode/execute stage: the memory write enable, the load flag, and the load size and sign-extension outputs of the instruction decoder.
- Drives a single valid/ready data-memory port and stalls the datapath until the access completes.
- Owns byte-lane masking, store-data replication, load-data alignment and sign/zero extension, misalignment detection and a bus timeout.

---
 rtl/memory_access_unit.sv | 209 ++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// memory_access_unit: sequences one data-memory load/store per instruction
// over a single valid/ready bus port. It handles byte-lane masks, store-data
// replication, load alignment and extension, misalignment rejection and a
// bus timeout.
module memory_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // Size 11 is never legal; halfwords need an even address, words a 4-aligned one.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_illegal = 1'b0;
      2'b01:   is_illegal = off[0];
      2'b10:   is_illegal = (off != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  // Byte enables for a store; a load never enables any lane.
  function automatic logic [3:0] lane_mask(input logic we, input logic [1:0] size,
                                           input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    lane_mask = we ? m : 4'b0000;
  endfunction

  // Replicate the store data so every possible lane carries the right byte(s).
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   replicate = {4{wd[7:0]}};
      2'b01:   replicate = {2{wd[15:0]}};
      default: replicate = wd;
    endcase
  endfunction

  // Move the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] align_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] size, input logic sext);
    logic [31:0] s;
    s = rd >> {off, 3'b000};
    case (size)
      2'b00:   align_load = sext ? {{24{s[7]}}, s[7:0]} : {24'h000000, s[7:0]};
      2'b01:   align_load = sext ? {{16{s[15]}}, s[15:0]} : {16'h0000, s[15:0]};
      default: align_load = s;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic          we_q, we_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_mis_q, err_mis_d;
  logic          err_to_q, err_to_d;

  // Next-state and datapath capture logic for the access FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    off_d     = off_q;
    size_d    = size_q;
    sext_d    = sext_q;
    we_d      = we_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_mis_d = 1'b0;
    err_to_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_illegal(req_size, req_addr[1:0])) begin
            err_mis_d = 1'b1;
            state_d   = ERROR;
          end else begin
            addr_d  = {req_addr[31:2], 2'b00};
            off_d   = req_addr[1:0];
            size_d  = req_size;
            sext_d  = req_sign_ext;
            we_d    = req_we;
            mask_d  = lane_mask(req_we, req_size, req_addr[1:0]);
            wdata_d = replicate(req_size, req_wdata);
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (!we_q) begin
            rdata_d = align_load(mem_rdata, off_q, size_q, sext_q);
          end else begin
            rdata_d = rdata_q;
          end
          done_d  = 1'b1;
          state_d = DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // This is the TIMEOUT_CYCLES-th cycle without a response.
          err_to_d = 1'b1;
          state_d  = ERROR;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset that aborts any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0000_0000;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      we_q      <= 1'b0;
      mask_q    <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      we_q      <= we_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
    end
  end

  assign mem_valid      = (state_q == ACCESS);
  assign mem_addr       = addr_q;
  assign mem_we         = we_q & mem_valid;
  assign mem_wmask      = mem_valid ? mask_q : 4'b0000;
  assign mem_wdata      = wdata_q;
  assign rdata          = rdata_q;
  assign done           = done_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;
  assign stall          = req_valid && (state_q != DONE) && (state_q != ERROR);

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed testbench for memory_access_unit: a table of single accesses
// followed by hand-written timeout, back-to-back and reset sequences.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_sign_ext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err_misaligned, err_timeout;
  logic [31:0] rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int total = 0;
  int bad = 0;

  memory_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_sign_ext(req_sign_ext), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          delay;
    logic        exp_err;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    bit finished, seen_valid, bus_bad;
    logic [31:0] a0, w0;
    logic [3:0] m0;
    logic we0, fin_done, fin_mis, fin_to, fin_stall;
    req_we = v.we; req_size = v.size; req_sign_ext = v.sext;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    mem_ready = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    #1;
    check($sformatf("v%0d stall_t", idx), {31'd0, stall}, 32'd1);
    lat = 0; finished = 1'b0; seen_valid = 1'b0; bus_bad = 1'b0;
    a0 = '0; w0 = '0; m0 = '0; we0 = 1'b0;
    fin_done = 1'b0; fin_mis = 1'b0; fin_to = 1'b0; fin_stall = 1'b1;
    while (!finished && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (mem_valid) begin
        if (!seen_valid) begin
          a0 = mem_addr; w0 = mem_wdata; m0 = mem_wmask; we0 = mem_we;
          check($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_maddr);
          check($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.we});
          check($sformatf("v%0d mem_wmask", idx), {28'd0, mem_wmask}, {28'd0, v.exp_wmask});
          if (v.we) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
          else check($sformatf("v%0d stall_acc", idx), {31'd0, stall}, 32'd1);
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_wmask !== m0 || mem_we !== we0) begin
          bus_bad = 1'b1;
        end
        seen_valid = 1'b1;
        if (lat - 1 == v.delay) begin
          mem_ready = 1'b1; mem_rdata = v.bus_rdata;
        end else begin
          mem_ready = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        end
      end else begin
        mem_ready = 1'b0;
        if (done || err_misaligned || err_timeout) begin
          finished = 1'b1;
          fin_done = done; fin_mis = err_misaligned; fin_to = err_timeout; fin_stall = stall;
        end
      end
    end
    mem_ready = 1'b0;
    check($sformatf("v%0d latency", idx), lat, v.exp_err ? 32'd1 : 32'(v.delay + 2));
    check($sformatf("v%0d done", idx), {31'd0, fin_done}, {31'd0, ~v.exp_err});
    check($sformatf("v%0d err_mis", idx), {31'd0, fin_mis}, {31'd0, v.exp_err});
    check($sformatf("v%0d err_to", idx), {31'd0, fin_to}, 32'd0);
    check($sformatf("v%0d stall_end", idx), {31'd0, fin_stall}, 32'd0);
    check($sformatf("v%0d bus_issued", idx), {31'd0, seen_valid}, {31'd0, ~v.exp_err});
    check($sformatf("v%0d bus_stable", idx), {31'd0, bus_bad}, 32'd0);
    check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d pulse_1cyc", idx), {30'd0, done, err_misaligned}, 32'd0);
  endtask

  initial begin
    //           we    size   sx    addr          wdata         bus_rdata     dly err   maddr         mask     wdata_exp     rdata_exp
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        3, 1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[3]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,        32'h1234_5678, 1, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,        32'h1234_5678};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0106, 32'h0,        32'h8765_4321, 0, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,        32'h0000_8765};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0106, 32'h0,        32'h8765_4321, 0, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,        32'hFFFF_8765};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        32'h0000_A500, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00A5};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h0,        0, 1'b0, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0000_00A5};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        2, 1'b0, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0000_00A5};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h1111_2222, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0000_00A5};
    vecs[11] = '{1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h3333_4444, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0000_00A5};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign_ext = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst flags", {28'd0, done, err_misaligned, err_timeout, mem_valid}, 32'd0);
    check("rst mem_we_mask", {27'd0, mem_we, mem_wmask}, 32'd0);
    check("rst rdata", rdata, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Timeout: word load with no bus response for 4 ACCESS cycles.
    req_we = 1'b0; req_size = 2'b10; req_sign_ext = 1'b0; req_addr = 32'h0000_0040;
    req_valid = 1'b1; mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("to valid_c%0d", c), {30'd0, mem_valid, done}, 32'd2);
    end
    @(posedge clk); #1;
    check("to err_timeout", {31'd0, err_timeout}, 32'd1);
    check("to mem_valid_low", {29'd0, mem_valid, done, err_misaligned}, 32'd0);
    check("to stall", {31'd0, stall}, 32'd0);
    check("to rdata_kept", rdata, 32'h0000_00A5);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("to idle", {29'd0, err_timeout, mem_valid, done}, 32'd0);

    // Back-to-back: lhu 0x8 then lb 0x9.
    req_we = 1'b0; req_size = 2'b01; req_sign_ext = 1'b0; req_addr = 32'h0000_0008;
    req_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b a_valid", {31'd0, mem_valid}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h0000_F00D;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("b2b a_done", {31'd0, done}, 32'd1);
    check("b2b a_rdata", rdata, 32'h0000_F00D);
    req_size = 2'b00; req_sign_ext = 1'b1; req_addr = 32'h0000_0009;
    @(posedge clk); #1;
    check("b2b idle_gap", {30'd0, mem_valid, stall}, 32'd1);
    @(posedge clk); #1;
    check("b2b b_valid", {31'd0, mem_valid}, 32'd1);
    check("b2b b_addr", mem_addr, 32'h0000_0008);
    mem_ready = 1'b1; mem_rdata = 32'h0000_7F00;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("b2b b_done", {31'd0, done}, 32'd1);
    check("b2b b_rdata", rdata, 32'h0000_007F);
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Reset asserted while an access is waiting on the bus.
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0020; req_wdata = 32'h0000_0001;
    req_valid = 1'b1;
    @(posedge clk); #1;
    check("rstmid valid", {31'd0, mem_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid valid_low", {31'd0, mem_valid}, 32'd0);
    check("rstmid stall_req", {31'd0, stall}, 32'd1);
    check("rstmid no_pulse", {29'd0, done, err_misaligned, err_timeout}, 32'd0);
    check("rstmid rdata", rdata, 32'h0);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("rstmid stall_drop", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("rstmid quiet", {28'd0, mem_valid, done, err_misaligned, err_timeout}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
